codec_init_sequencer: RTL

//  Power-up configuration controller for the audio codec. Walks a fixed table of register writes and issues

---
 rtl/codec_pkg.sv | 36 +++
 rtl/codec_reg_rom.sv | 51 +++++
 rtl/codec_init_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/codec_pkg.sv
// -----------------------------------------------------------------------------
// codec_pkg
// Shared definitions for the audio codec power-up sequencer:
//   - state_t      : sequencer state codes, also shown on the debug display
//   - REG_*        : WM8731 control register addresses
//   - pack_word    : builds the 16-bit control word {reg_addr[6:0], reg_data[8:0]}
// -----------------------------------------------------------------------------
package codec_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP   = 4'd0,
        ST_ISSUE     = 4'd1,
        ST_WAIT_DONE = 4'd2,
        ST_GAP       = 4'd3,
        ST_READY     = 4'd4,
        ST_FAIL      = 4'd5
    } state_t;

    // WM8731 register map
    localparam logic [6:0] REG_LINVOL = 7'h00;
    localparam logic [6:0] REG_RINVOL = 7'h01;
    localparam logic [6:0] REG_LHPOUT = 7'h02;
    localparam logic [6:0] REG_RHPOUT = 7'h03;
    localparam logic [6:0] REG_APANA  = 7'h04;
    localparam logic [6:0] REG_APDIGI = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_DAIF   = 7'h07;
    localparam logic [6:0] REG_SAMPLE = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    function automatic logic [15:0] pack_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// -----------------------------------------------------------------------------
// codec_reg_rom
// Combinational table of codec register writes issued at power-up.
// Entry 0 resets the codec; the last entry (NUM_REGS-1) always activates the
// digital interface, so the codec only starts once everything else is set up.
// Ports:
//   i_index  in  4   table entry to read
//   o_word   out 16  packed {reg_addr[6:0], reg_data[8:0]}
// -----------------------------------------------------------------------------
module codec_reg_rom
    import codec_pkg::*;
#(
    parameter int NUM_REGS = 10
) (
    input  logic [3:0]  i_index,
    output logic [15:0] o_word
);

    localparam logic [3:0] LAST_INDEX = 4'(NUM_REGS - 1);

    always_comb begin
        // Unused slots fall back to a harmless "all blocks powered" write.
        o_word = pack_word(REG_PWR, 9'h000);
        if (i_index == LAST_INDEX) begin
            o_word = pack_word(REG_ACTIVE, 9'h001);
        end else begin
            case (i_index)
                4'd0:    o_word = pack_word(REG_RESET,  9'h000);
                // Power everything except the output stage until the end,
                // avoiding pops while the analog path is being configured.
                4'd1:    o_word = pack_word(REG_PWR,    9'h010);
                // Line-in 0 dB, unmuted, applied to both channels (bit 8).
                4'd2:    o_word = pack_word(REG_LINVOL, 9'h117);
                // Headphone 0 dB, zero-cross, both channels.
                4'd3:    o_word = pack_word(REG_LHPOUT, 9'h179);
                // DAC selected to output, mic muted.
                4'd4:    o_word = pack_word(REG_APANA,  9'h012);
                // De-emphasis off, DAC soft-mute off.
                4'd5:    o_word = pack_word(REG_APDIGI, 9'h000);
                // Slave mode, I2S format, 24-bit words.
                4'd6:    o_word = pack_word(REG_DAIF,   9'h00A);
                // Normal mode, 48 kHz.
                4'd7:    o_word = pack_word(REG_SAMPLE, 9'h000);
                // Now power the output stage as well.
                4'd8:    o_word = pack_word(REG_PWR,    9'h000);
                default: o_word = pack_word(REG_PWR,    9'h000);
            endcase
        end
    end

endmodule

// File: rtl/codec_init_sequencer.sv
// -----------------------------------------------------------------------------
// codec_init_sequencer
// Power-up configuration controller for the audio codec. After a power-up
// delay it walks the register table, issuing each write to the I2C master via
// a req/done handshake, retrying NACKed or timed-out writes, and finally
// raises o_codec_ready (or o_init_fail when an entry runs out of retries).
// Ports:
//   i_clk           in   1   slow system clock (1 MHz)
//   i_rst_n         in   1   asynchronous active-low reset
//   i_restart       in   1   pulse: re-run the table, honoured in READY/FAIL
//   i_i2c_busy      in   1   I2C master mid-transaction
//   i_i2c_done      in   1   1-cycle pulse, transaction finished
//   i_i2c_ack_err   in   1   valid with done, 1 = slave NACK
//   o_i2c_req       out  1   1-cycle transaction request
//   o_i2c_dev_addr  out  7   codec I2C address
//   o_i2c_word      out  16  {reg_addr, reg_data} for the current entry
//   o_codec_ready   out  1   whole table written
//   o_init_fail     out  1   an entry exhausted its retries
//   o_write_index   out  4   current table entry
//   o_state_info    out  4   state code for the debug display
// -----------------------------------------------------------------------------
module codec_init_sequencer
    import codec_pkg::*;
#(
    parameter int          NUM_REGS     = 10,
    parameter logic [6:0]  DEVICE_ADDR  = 7'h1A,
    parameter logic [31:0] POWERUP_WAIT = 32'd1000,
    parameter logic [15:0] GAP_CYCLES   = 16'd16,
    parameter logic [15:0] TIMEOUT      = 16'd2000,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_restart,
    input  logic        i_i2c_busy,
    input  logic        i_i2c_done,
    input  logic        i_i2c_ack_err,
    output logic        o_i2c_req,
    output logic [6:0]  o_i2c_dev_addr,
    output logic [15:0] o_i2c_word,
    output logic        o_codec_ready,
    output logic        o_init_fail,
    output logic [3:0]  o_write_index,
    output logic [3:0]  o_state_info
);

    localparam logic [3:0] LAST_INDEX  = 4'(NUM_REGS - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

    state_t      r_state, w_state_next;
    logic [31:0] r_cnt, w_cnt_next;
    logic [3:0]  r_index, w_index_next;
    logic [2:0]  r_retry, w_retry_next;
    logic        r_req, w_req_next;
    logic [15:0] r_word, w_word_next;
    logic        r_ready, w_ready_next;
    logic        r_fail, w_fail_next;

    logic [15:0] w_rom_word;
    logic        w_powerup_done;
    logic        w_gap_done;
    logic        w_timeout;

    codec_reg_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .i_index (r_index),
        .o_word  (w_rom_word)
    );

    // One shared counter serves POWERUP, WAIT_DONE and GAP; it is cleared on
    // every state entry that uses it. Comparisons are ">=" so a zero-length
    // setting degenerates to a single cycle instead of wrapping.
    assign w_powerup_done = ({1'b0, r_cnt} + 33'd1) >= {1'b0, POWERUP_WAIT};
    assign w_gap_done     = (r_cnt + 32'd1) >= {16'd0, GAP_CYCLES};
    // The counter is 0 in the req cycle; the write fails on the edge where the
    // incremented count reaches TIMEOUT-1, so a req repeats every
    // TIMEOUT+GAP_CYCLES cycles when the master never answers.
    assign w_timeout      = (r_cnt + 32'd2) >= {16'd0, TIMEOUT};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_POWERUP;
            r_cnt   <= '0;
            r_index <= '0;
            r_retry <= '0;
            r_req   <= 1'b0;
            r_word  <= '0;
            r_ready <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_index <= w_index_next;
            r_retry <= w_retry_next;
            r_req   <= w_req_next;
            r_word  <= w_word_next;
            r_ready <= w_ready_next;
            r_fail  <= w_fail_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_index_next = r_index;
        w_retry_next = r_retry;
        w_req_next   = 1'b0;
        w_word_next  = r_word;
        w_ready_next = r_ready;
        w_fail_next  = r_fail;

        case (r_state)
            ST_POWERUP: begin
                if (w_powerup_done) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end

            ST_ISSUE: begin
                // The word is loaded on the same edge that raises req, so it
                // is stable for the master for the whole transaction.
                w_word_next = w_rom_word;
                if (!i_i2c_busy) begin
                    w_req_next   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                w_cnt_next = r_cnt + 32'd1;
                // done is tested first so it wins over a coincident timeout.
                if (i_i2c_done && !i_i2c_ack_err) begin
                    w_retry_next = '0;
                    w_cnt_next   = '0;
                    if (r_index == LAST_INDEX) begin
                        w_ready_next = 1'b1;
                        w_state_next = ST_READY;
                    end else begin
                        w_index_next = r_index + 4'd1;
                        w_state_next = ST_GAP;
                    end
                end else if (i_i2c_done || w_timeout) begin
                    w_cnt_next = '0;
                    if (r_retry < RETRY_LIMIT) begin
                        w_retry_next = r_retry + 3'd1;
                        w_state_next = ST_GAP;
                    end else begin
                        w_fail_next  = 1'b1;
                        w_state_next = ST_FAIL;
                    end
                end
            end

            ST_GAP: begin
                if (w_gap_done) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end

            ST_READY, ST_FAIL: begin
                // The codec is already powered, so a restart skips POWERUP.
                if (i_restart) begin
                    w_ready_next = 1'b0;
                    w_fail_next  = 1'b0;
                    w_index_next = '0;
                    w_retry_next = '0;
                    w_cnt_next   = '0;
                    w_state_next = ST_ISSUE;
                end
            end

            default: begin
                w_state_next = ST_POWERUP;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_i2c_req      = r_req;
    assign o_i2c_dev_addr = DEVICE_ADDR;
    assign o_i2c_word     = r_word;
    assign o_codec_ready  = r_ready;
    assign o_init_fail    = r_fail;
    assign o_write_index  = r_index;
    assign o_state_info   = r_state;

endmodule
